// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path (and the planned receiver).
//   PAR_NONE / PAR_EVEN / PAR_ODD : parity-mode encodings of cfg_parity
//                                   (2'b11 also means no parity)
//   uart_tx_state_t               : serialiser FSM state encoding
//   parity_enabled()              : true when a mode inserts a parity bit
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with an explicit occupancy counter.
//   clk, reset  : rising-edge clock, asynchronous active-high reset
//   push        : write push_data (ignored when full)
//   push_data   : entry to write
//   pop         : drop the head entry (ignored when empty)
//   pop_data    : current head entry (valid when !empty)
//   level       : number of stored entries, 0..DEPTH
//   full, empty : level == DEPTH / level == 0
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (level_q == LVL_W'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign pop_data = mem[rd_ptr_q];
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            // Simultaneous push and pop leave the level unchanged.
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered, runtime-configurable UART transmitter.
//   clk, reset    : rising-edge clock, asynchronous active-high reset
//   cfg_div       : bit period in cycles minus one
//   cfg_parity    : 00 none, 01 even, 10 odd, 11 none
//   cfg_stop2     : 0 = one stop bit, 1 = two stop bits
//   tx_data       : byte to queue
//   tx_valid      : tx_data valid; pushed when tx_valid && tx_ready
//   tx_ready      : FIFO not full
//   uart_txd      : registered serial line, idles high
//   uart_tx_busy  : serialiser active or FIFO non-empty
//   fifo_level    : current FIFO occupancy
// Frame configuration is latched when a byte is popped, so changes made
// mid-frame only affect the following frame.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int PAYLOAD_BITS = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int DIV_WIDTH    = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DIV_WIDTH-1:0]          cfg_div,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    input  logic [PAYLOAD_BITS-1:0]       tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_txd,
    output logic                          uart_tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CNT_W = $clog2(PAYLOAD_BITS + 1);

    uart_tx_state_t          state_q;
    uart_tx_state_t          state_d;

    logic [DIV_WIDTH-1:0]    bit_cnt_q;
    logic [DIV_WIDTH-1:0]    div_q;
    logic [1:0]              par_q;
    logic                    stop2_q;
    logic                    par_bit_q;
    logic                    stop_idx_q;
    logic [CNT_W-1:0]        data_idx_q;
    logic [PAYLOAD_BITS-1:0] shift_q;
    logic                    txd_q;
    logic                    txd_d;

    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [PAYLOAD_BITS-1:0] fifo_head;
    logic                    bit_end;

    assign tx_ready     = ~fifo_full;
    assign fifo_push    = tx_valid && tx_ready;
    assign uart_txd     = txd_q;
    assign uart_tx_busy = (state_q != IDLE) || !fifo_empty;
    assign bit_end      = (bit_cnt_q == div_q);

    uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PAYLOAD_BITS)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (tx_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end && (data_idx_q == CNT_W'(PAYLOAD_BITS - 1))) begin
                    state_d = parity_enabled(par_q) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                // Last stop period: chain straight into the next frame if queued.
                if (bit_end && (!stop2_q || stop_idx_q)) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = START;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level for the current state; registered below so the pin lags
    // the state by exactly one cycle for every bit.
    always_comb begin
        txd_d = 1'b1;
        case (state_q)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_q[0];
            PARITY:  txd_d = par_bit_q;
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt_q  <= '0;
            div_q      <= '0;
            par_q      <= PAR_NONE;
            stop2_q    <= 1'b0;
            par_bit_q  <= 1'b0;
            stop_idx_q <= 1'b0;
            data_idx_q <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
        end else begin
            txd_q <= txd_d;
            if (fifo_pop) begin
                shift_q    <= fifo_head;
                div_q      <= cfg_div;
                par_q      <= cfg_parity;
                stop2_q    <= cfg_stop2;
                par_bit_q  <= (cfg_parity == PAR_ODD) ? ~(^fifo_head) : ^fifo_head;
                bit_cnt_q  <= '0;
                data_idx_q <= '0;
                stop_idx_q <= 1'b0;
            end else if (state_q != IDLE) begin
                if (bit_end) begin
                    bit_cnt_q <= '0;
                    if (state_q == DATA) begin
                        shift_q    <= shift_q >> 1;
                        data_idx_q <= data_idx_q + CNT_W'(1);
                    end
                    if (state_q == STOP) begin
                        stop_idx_q <= 1'b1;
                    end
                end else begin
                    bit_cnt_q <= bit_cnt_q + DIV_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo. Inputs and outputs are recorded per
// clock edge; a timeline model (frame start = max(accept+2, previous frame
// end), configuration taken at the pop edge) predicts the pin, level,
// ready and busy for every recorded cycle.
module tb_uart_tx_fifo;

    localparam int PB    = 8;
    localparam int DEPTH = 4;
    localparam int DW    = 16;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int MAXE  = 8192;
    localparam int MAXF  = 1024;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] cfg_div = '0;
    logic [1:0]    cfg_parity = 2'b00;
    logic          cfg_stop2 = 1'b0;
    logic [PB-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          uart_txd;
    logic          uart_tx_busy;
    logic [LW-1:0] fifo_level;

    int nchecks = 0;
    int npass   = 0;

    uart_tx_fifo #(
        .PAYLOAD_BITS (PB),
        .FIFO_DEPTH   (DEPTH),
        .DIV_WIDTH    (DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_div      (cfg_div),
        .cfg_parity   (cfg_parity),
        .cfg_stop2    (cfg_stop2),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .uart_txd     (uart_txd),
        .uart_tx_busy (uart_tx_busy),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    // ---------------- recorder ----------------
    bit            rec_on = 1'b0;
    int            ne = 0;
    int            nacc = 0;
    logic [DW-1:0] r_div  [MAXE];
    logic [1:0]    r_par  [MAXE];
    logic          r_st   [MAXE];
    logic          r_txd  [MAXE];
    logic          r_rdy  [MAXE];
    logic          r_busy [MAXE];
    logic [LW-1:0] r_lvl  [MAXE];
    int            acc_e  [MAXF];
    logic [PB-1:0] acc_d  [MAXF];

    always @(posedge clk) begin
        if (rec_on && !reset && ne < MAXE - 1) begin
            ne = ne + 1;
            r_div[ne] = cfg_div;
            r_par[ne] = cfg_parity;
            r_st[ne]  = cfg_stop2;
            if (tx_valid && tx_ready && nacc < MAXF) begin
                acc_e[nacc] = ne;
                acc_d[nacc] = tx_data;
                nacc = nacc + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rec_on) begin
            r_txd[ne]  = uart_txd;
            r_rdy[ne]  = tx_ready;
            r_busy[ne] = uart_tx_busy;
            r_lvl[ne]  = fifo_level;
        end
    end

    // ---------------- model ----------------
    int            f_s   [MAXF];
    int            f_e   [MAXF];
    int            f_pe  [MAXF];
    int            f_div [MAXF];
    logic [1:0]    f_par [MAXF];
    logic [PB-1:0] f_dat [MAXF];

    function automatic logic frame_bit(input logic [PB-1:0] d, input int div,
                                       input logic [1:0] par, input int off);
        int b;
        b = off / (div + 1);
        if (b == 0)                       return 1'b0;
        if (b <= PB)                      return d[b-1];
        if (b == PB + 1 && par == 2'b01)  return ^d;
        if (b == PB + 1 && par == 2'b10)  return ~(^d);
        return 1'b1;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rec_on   = 1'b0;
        tx_valid = 1'b0;
        reset    = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic start_trace();
        ne        = 0;
        nacc      = 0;
        r_txd[0]  = uart_txd;
        r_rdy[0]  = tx_ready;
        r_busy[0] = uart_tx_busy;
        r_lvl[0]  = fifo_level;
        rec_on    = 1'b1;
    endtask

    task automatic drain(input string name, input int budget);
        int g;
        g = 0;
        tx_valid = 1'b0;
        while (uart_tx_busy && g < budget) begin
            tick();
            g++;
        end
        nchecks++;
        if (uart_tx_busy !== 1'b0) $display("FAIL %s drain: busy=%b after %0d cycles, required 0", name, uart_tx_busy, g);
        else npass++;
        repeat (4) tick();
        rec_on = 1'b0;
    endtask

    task automatic check_trace(input string name);
        int nf, eprev, ai, pi, fi, lvl;
        logic exp_txd, active;
        nf = 0;
        eprev = 0;
        for (int k = 0; k < nacc; k++) begin
            int s, nbits;
            s = acc_e[k] + 2;
            if (s < eprev) s = eprev;
            if (s - 1 > ne) break;
            f_pe[nf]  = s - 1;
            f_s[nf]   = s;
            f_div[nf] = int'(r_div[s-1]);
            f_par[nf] = r_par[s-1];
            f_dat[nf] = acc_d[k];
            nbits = 1 + PB + ((f_par[nf] == 2'b01 || f_par[nf] == 2'b10) ? 1 : 0)
                    + (r_st[s-1] ? 2 : 1);
            f_e[nf] = s + (f_div[nf] + 1) * nbits;
            eprev = f_e[nf];
            nf++;
        end
        ai = 0; pi = 0; fi = 0; lvl = 0;
        for (int t = 0; t <= ne; t++) begin
            while (ai < nacc && acc_e[ai] <= t) begin lvl++; ai++; end
            while (pi < nf && f_pe[pi] <= t) begin lvl--; pi++; end
            while (fi < nf && f_e[fi] <= t) fi++;
            exp_txd = 1'b1;
            active  = 1'b0;
            if (fi < nf && f_s[fi] <= t)
                exp_txd = frame_bit(f_dat[fi], f_div[fi], f_par[fi], t - f_s[fi]);
            for (int j = fi; j < fi + 2 && j < nf; j++)
                if (f_pe[j] <= t && t < f_e[j] - 1) active = 1'b1;
            nchecks++;
            if (r_txd[t] !== exp_txd) $display("FAIL %s txd @%0d: got %b required %b", name, t, r_txd[t], exp_txd);
            else npass++;
            nchecks++;
            if (r_lvl[t] !== LW'(lvl)) $display("FAIL %s level @%0d: got %0d required %0d", name, t, r_lvl[t], lvl);
            else npass++;
            nchecks++;
            if (r_rdy[t] !== (lvl != DEPTH)) $display("FAIL %s ready @%0d: got %b required %b", name, t, r_rdy[t], lvl != DEPTH);
            else npass++;
            nchecks++;
            if (r_busy[t] !== (active || lvl != 0)) $display("FAIL %s busy @%0d: got %b required %b", name, t, r_busy[t], active || lvl != 0);
            else npass++;
        end
    endtask

    task automatic push_byte(input logic [PB-1:0] d, input int budget);
        int g;
        g = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && g < budget) begin tick(); g++; end
        tick();
        tx_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        nchecks++; if (uart_txd !== 1'b1)     $display("FAIL reset txd: got %b required 1", uart_txd);         else npass++;
        nchecks++; if (tx_ready !== 1'b1)     $display("FAIL reset ready: got %b required 1", tx_ready);       else npass++;
        nchecks++; if (uart_tx_busy !== 1'b0) $display("FAIL reset busy: got %b required 0", uart_tx_busy);    else npass++;
        nchecks++; if (fifo_level !== '0)     $display("FAIL reset level: got %0d required 0", fifo_level);    else npass++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        nchecks++; if (uart_txd !== 1'b1)     $display("FAIL reset-release txd: got %b required 1", uart_txd); else npass++;
    endtask

    task automatic test_basic();
        do_reset();
        cfg_div = 3; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        start_trace();
        push_byte(8'hA5, 10);
        drain("basic", 200);
        check_trace("basic");
    endtask

    task automatic test_parity();
        logic [PB-1:0] dat  [3] = '{8'h07, 8'h07, 8'h00};
        logic [1:0]    mode [3] = '{2'b01, 2'b10, 2'b01};
        logic          expp [3] = '{1'b1, 1'b0, 1'b0};
        do_reset();
        cfg_div = 2; cfg_stop2 = 1'b0;
        start_trace();
        for (int i = 0; i < 3; i++) begin
            int a;
            cfg_parity = mode[i];
            push_byte(dat[i], 10);
            a = acc_e[i];
            drain("parity", 200);
            rec_on = 1'b1;
            nchecks++;
            if (r_txd[a + 2 + (PB + 1) * 3 + 1] !== expp[i])
                $display("FAIL parity bit %0d: got %b required %b", i, r_txd[a + 2 + (PB + 1) * 3 + 1], expp[i]);
            else npass++;
        end
        rec_on = 1'b0;
        check_trace("parity");
    endtask

    task automatic test_back_to_back();
        int acc, g;
        do_reset();
        cfg_div = 15; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        start_trace();
        acc = 0; g = 0;
        tx_valid = 1'b1;
        while (tx_ready && g < 20) begin
            tx_data = PB'(32'h10 + acc);
            acc++;
            tick();
            g++;
        end
        nchecks++; if (acc !== 5)          $display("FAIL b2b accepts: got %0d required 5", acc);         else npass++;
        nchecks++; if (fifo_level !== LW'(4)) $display("FAIL b2b level: got %0d required 4", fifo_level);  else npass++;
        push_byte(8'h15, 1000);
        drain("b2b", 3000);
        check_trace("b2b");
    endtask

    task automatic test_stop2();
        do_reset();
        cfg_div = 1; cfg_parity = 2'b00; cfg_stop2 = 1'b1;
        start_trace();
        push_byte(8'hFF, 10);
        push_byte(8'h5A, 10);
        drain("stop2", 300);
        check_trace("stop2");
    endtask

    task automatic test_cfg_change();
        do_reset();
        cfg_div = 3; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        start_trace();
        push_byte(8'h3C, 10);
        push_byte(8'hC3, 10);
        repeat (8) tick();
        cfg_div = 7;
        drain("cfgchg", 500);
        check_trace("cfgchg");
    endtask

    task automatic test_random();
        do_reset();
        cfg_div = 1; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        start_trace();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(7) == 0) begin
                cfg_div    = DW'($urandom_range(3));
                cfg_parity = 2'($urandom_range(3));
                cfg_stop2  = 1'($urandom_range(1));
            end
            tx_valid = ($urandom_range(2) == 0);
            tx_data  = PB'($urandom);
            tick();
        end
        drain("random", 1000);
        check_trace("random");
    endtask

    task automatic test_reset_midframe();
        int bad;
        do_reset();
        cfg_div = 3; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        tx_valid = 1'b1;
        tx_data = 8'h00; tick();
        tx_data = 8'h81; tick();
        tx_data = 8'h42; tick();
        tx_valid = 1'b0;
        repeat (5) tick();
        nchecks++; if (uart_txd !== 1'b0)     $display("FAIL midrst pre txd: got %b required 0", uart_txd);       else npass++;
        nchecks++; if (fifo_level !== LW'(2)) $display("FAIL midrst pre level: got %0d required 2", fifo_level); else npass++;
        reset = 1'b1;
        #1;
        nchecks++; if (uart_txd !== 1'b1)     $display("FAIL midrst txd: got %b required 1", uart_txd);           else npass++;
        nchecks++; if (fifo_level !== '0)     $display("FAIL midrst level: got %0d required 0", fifo_level);     else npass++;
        nchecks++; if (uart_tx_busy !== 1'b0) $display("FAIL midrst busy: got %b required 0", uart_tx_busy);      else npass++;
        tick();
        reset = 1'b0;
        #1;
        nchecks++; if (tx_ready !== 1'b1)     $display("FAIL midrst ready: got %b required 1", tx_ready);         else npass++;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (uart_txd !== 1'b1 || uart_tx_busy !== 1'b0) bad++;
        end
        nchecks++; if (bad !== 0) $display("FAIL midrst residual: got %0d active cycles required 0", bad); else npass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_stop2();
        test_cfg_change();
        test_random();
        test_reset_midframe();
        $display("%0d/%0d checks passed", npass, nchecks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered, runtime-configurable UART transmitter for the SoC peripheral bus. It accepts bytes over a valid/ready handshake into a small FIFO and serialises them LSB-first. Baud divisor, parity mode and stop-bit count are all programmable at runtime. It is the successor to the fixed-rate single-byte transmitter, and it lets the CPU queue several bytes without polling per byte.

## Interface
Parameters:
- `PAYLOAD_BITS`, 8: data bits per frame (5–9).
- `FIFO_DEPTH`, 4: FIFO entries; must be a power of two and ≥2.
- `DIV_WIDTH`, 16: width of the baud divisor.

Ports:
- `clk`  in  1  system clock; everything is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cfg_div`  in  DIV_WIDTH  bit period in cycles minus one.
- `cfg_parity`  in  2  parity mode: 00 none, 01 even, 10 odd, 11 none.
- `cfg_stop2`  in  1  0 = one stop bit, 1 = two stop bits.
- `tx_data`  in  PAYLOAD_BITS  byte to queue.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  FIFO can accept a byte.
- `uart_txd`  out  1  serial line (registered).
- `uart_tx_busy`  out  1  serialiser active or FIFO non-empty.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Push occurs when `tx_valid && tx_ready`.
- `tx_ready = (fifo_level != FIFO_DEPTH)`. It depends on level only, so a push is never accepted into a full FIFO, even in a cycle where a pop also happens.
- Serialiser FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE → START when the FIFO is non-empty. On that transition:
  - the head entry is popped into the shift register;
  - `cfg_div`, `cfg_parity` and `cfg_stop2` are latched for the whole frame.
- Each state lasts exactly `cfg_div+1` cycles per bit, timed by a bit counter that reloads on every bit boundary. `cfg_div=0` gives one cycle per bit.
- DATA shifts out `PAYLOAD_BITS` bits, LSB first.
- PARITY is present only when parity mode is 01 or 10:
  - even mode sends the XOR of the data bits;
  - odd mode sends the inverted XOR.
- STOP lasts 1 or 2 bit periods according to the latched `cfg_stop2`.
- At the end of STOP:
  - if the FIFO is non-empty, pop and go directly to START, with no idle cycle between frames;
  - otherwise go to IDLE.
- Configuration changes during a frame take effect only on the next frame.
- `uart_tx_busy = (state != IDLE) || (fifo_level != 0)`.
- The FIFO pointers wrap modulo `FIFO_DEPTH`. `fifo_level` is an explicit counter:
  - +1 on push only, −1 on pop only;
  - unchanged when push and pop happen in the same cycle.

## Timing
- Reset values: `uart_txd=1`, `tx_ready=1`, `uart_tx_busy=0`, `fifo_level=0`; FSM in IDLE; FIFO empty; bit counter 0.
- Reset applies asynchronously: `uart_txd` goes high immediately, including mid-frame. Any partially sent frame and all queued bytes are discarded.
- Latency with an idle serialiser: push on edge N → `fifo_level=1` after N → pop and START on edge N+1 → `uart_txd` falls after edge N+2. The start bit then lasts `cfg_div+1` cycles.
- `uart_txd` is registered from the FSM state and shift register, so the line lags the state by one cycle. Every bit therefore spans exactly `cfg_div+1` cycles on the pin.
- `uart_tx_busy` deasserts on the cycle the FSM returns to IDLE with an empty FIFO. This is one cycle before the final stop-bit period completes on the pin.

## Structure
- Shared package `uart_pkg` holds:
  - parity-mode constants `PAR_NONE`, `PAR_EVEN`, `PAR_ODD`;
  - FSM state encoding, a 3-bit enum `uart_tx_state_t`.
- One sub-module, `uart_fifo`: a synchronous FIFO with parameters DEPTH and WIDTH, providing push, pop, level, full and empty. It will be reused by the planned receiver.
- The serialiser FSM, bit counter and shift register live in `uart_tx_fifo`.

## Test plan
- **Basic frame:** `cfg_div=3`, parity none, one stop bit, push 0xA5. Expect the start bit low for 4 cycles beginning 2 cycles after the accept, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles. Busy then drops and `fifo_level` returns to 0.
- **Parity:** push 0x07 in even mode → parity bit 1. Push 0x07 in odd mode → parity bit 0. Push 0x00 in even mode → parity bit 0.
- **FIFO full and back-to-back:** `cfg_div=15`, hold `tx_valid` with 0x10..0x15. Expect exactly 5 accepts before `tx_ready` drops (1 in flight plus 4 queued), with `fifo_level=4`. Frames must be emitted with no idle cycle between the stop bit and the next start bit.
- **Two stop bits:** `cfg_stop2=1`, `cfg_div=1`. The stop level must stay high for exactly 4 cycles before the next start bit.
- **Mid-frame config change:** change `cfg_div` from 3 to 7 during DATA. The current frame keeps 4-cycle bits; the next queued frame uses 8-cycle bits.
- **Reset mid-frame:** assert `reset` during DATA with 2 bytes queued. `uart_txd` goes to 1 immediately, `fifo_level=0`, `uart_tx_busy=0`. After release, `tx_ready=1` and no residual frame is sent.
